shared_mem_arbiter: RTL

- Round-robin arbiter that shares one single-port 8192x32 on-chip RAM (byte-enabled, 1-cycle read latency) between NUM_MASTERS core-side Avalon-MM masters.
- Sits between the per-core data masters and the shared memory slave.
- Issues at most one transfer per cycle and routes read data back with readdatavalid.
- Supports a per-master lock for atomic read-modify-write sequences, with a timeout.

---
 rtl/shared_mem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port byte-enabled RAM (1-cycle read
// latency) among NUM_MASTERS Avalon-MM masters, with per-master lock and timeout.
module shared_mem_arbiter #(
  parameter int NUM_MASTERS  = 5,
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
  input  logic [NUM_MASTERS-1:0]          m_read,
  input  logic [NUM_MASTERS-1:0]          m_write,
  input  logic [NUM_MASTERS-1:0]          m_lock,
  output logic [NUM_MASTERS-1:0]          m_waitrequest,
  output logic [DATA_W-1:0]               m_readdata,
  output logic [NUM_MASTERS-1:0]          m_readdatavalid,
  output logic [ADDR_W-1:0]               mem_address,
  output logic [DATA_W/8-1:0]             mem_byteenable,
  output logic [DATA_W-1:0]               mem_writedata,
  output logic                            mem_chipselect,
  output logic                            mem_write,
  output logic                            mem_clken,
  input  logic [DATA_W-1:0]               mem_readdata,
  output logic                            lock_timeout_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [0:0] {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         lock_owner;
  logic [7:0]               idle_cnt;
  logic [NUM_MASTERS-1:0]   rd_pend;
  logic                     err;

  logic [NUM_MASTERS-1:0]   req;
  logic [NUM_MASTERS-1:0]   grant;
  logic [IDX_W-1:0]         gidx;
  logic                     found;
  logic                     wr_g;
  logic                     rd_g;
  logic                     lock_g;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_MASTERS - 1)) begin
      next_idx = '0;
    end else begin
      next_idx = i + IDX_W'(1);
    end
  endfunction

  assign req = m_read | m_write;

  // Pick this cycle's grant: owner only while locked, else round-robin from rr_ptr.
  always_comb begin : grant_sel
    int cand;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = 0;
    if (!reset_n) begin
      found = 1'b0;
    end else if (state == LOCKED) begin
      if (req[lock_owner]) begin
        grant[lock_owner] = 1'b1;
        gidx              = lock_owner;
        found             = 1'b1;
      end else begin
        found = 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NUM_MASTERS) begin
          cand = cand - NUM_MASTERS;
        end else begin
          cand = cand;
        end
        if (!found && req[cand]) begin
          grant[cand] = 1'b1;
          gidx        = IDX_W'(cand);
          found       = 1'b1;
        end else begin
          found = found;
        end
      end
    end
  end

  // A simultaneous read+write from one master is treated as a write only.
  assign wr_g   = found & m_write[gidx];
  assign rd_g   = found & m_read[gidx] & ~m_write[gidx];
  assign lock_g = found & m_lock[gidx];

  assign m_waitrequest   = ~grant;
  assign mem_address     = m_address[int'(gidx)*ADDR_W +: ADDR_W];
  assign mem_byteenable  = m_byteenable[int'(gidx)*BE_W +: BE_W];
  assign mem_writedata   = m_writedata[int'(gidx)*DATA_W +: DATA_W];
  assign mem_chipselect  = found;
  assign mem_write       = wr_g;
  assign mem_clken       = reset_n;
  assign m_readdata      = mem_readdata;
  assign m_readdatavalid = rd_pend;
  assign lock_timeout_err = err;

  // Arbitration state, lock tracking and read-return pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= UNLOCKED;
      rr_ptr     <= '0;
      lock_owner <= '0;
      idle_cnt   <= 8'd0;
      rd_pend    <= '0;
      err        <= 1'b0;
    end else begin
      rd_pend <= rd_g ? grant : '0;
      case (state)
        UNLOCKED: begin
          if (found) begin
            if (lock_g) begin
              state      <= LOCKED;
              lock_owner <= gidx;
              idle_cnt   <= 8'd0;
            end else begin
              rr_ptr <= next_idx(gidx);
            end
          end else begin
            rr_ptr <= rr_ptr;
          end
        end
        LOCKED: begin
          if (found) begin
            if (lock_g) begin
              idle_cnt <= 8'd0;
            end else begin
              state  <= UNLOCKED;
              rr_ptr <= next_idx(lock_owner);
            end
          end else if (idle_cnt == 8'(LOCK_TIMEOUT - 1)) begin
            state  <= UNLOCKED;
            rr_ptr <= next_idx(lock_owner);
            err    <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        default: begin
          state <= UNLOCKED;
        end
      endcase
    end
  end

endmodule
